// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg: shared mode encodings, trigger bit indices and status layout
package pattern_gen_pkg;
  typedef enum logic [1:0] {GEN_LFSR = 2'b01, GEN_CNT = 2'b10} gen_e;
  typedef enum logic [2:0] {RUN_OFF = 3'b001, RUN_CONT = 3'b010, RUN_PIPED = 3'b100} run_e;
  localparam int TRIG_LFSR = 0;
  localparam int TRIG_CNT = 1;
  localparam int TRIG_OFF = 2;
  localparam int TRIG_CONT = 3;
  localparam int TRIG_PIPED = 4;
  localparam int TRIG_BCAST = 5;
  localparam int TRIG_CLR_ERR = 6;
  localparam int ST_GEN_LSB = 0;
  localparam int ST_RUN_LSB = 2;
  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;
endpackage

// File: rtl/pattern_chan.sv
// pattern_chan: one generator channel with value/mode registers, step logic and LFSR zero guard
module pattern_chan import pattern_gen_pkg::*; #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_trig,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic             i_step_req,
  output logic [WIDTH-1:0] o_val,
  output gen_e             o_gen,
  output run_e             o_run
);
  logic [WIDTH-1:0] r_val, w_stepped, w_raw, w_val_nxt;
  gen_e r_gen, w_gen_nxt;
  run_e r_run, w_run_nxt;
  logic w_step, w_guard;
  // mode priority, step with the current mode, then keep an LFSR out of the all-zero state on entry
  always_comb begin
    w_gen_nxt = i_trig[TRIG_CNT] ? GEN_CNT : i_trig[TRIG_LFSR] ? GEN_LFSR : r_gen;
    w_run_nxt = i_trig[TRIG_PIPED] ? RUN_PIPED : i_trig[TRIG_CONT] ? RUN_CONT : i_trig[TRIG_OFF] ? RUN_OFF : r_run;
    w_step = (r_run == RUN_CONT) || (r_run == RUN_PIPED && i_step_req);
    w_stepped = (r_gen == GEN_CNT) ? r_val + WIDTH'(1) : {r_val[WIDTH-2:0], ^(r_val & TAPS)};
    w_raw = i_seed_load ? i_seed : w_step ? w_stepped : r_val;
    w_guard = (w_gen_nxt == GEN_LFSR) && (i_seed_load || r_gen != GEN_LFSR) && (w_raw == '0);
    w_val_nxt = w_guard ? WIDTH'(1) : w_raw;
  end
  // channel state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_val <= WIDTH'(1);
      r_gen <= GEN_LFSR;
      r_run <= RUN_OFF;
    end else begin
      r_val <= w_val_nxt;
      r_gen <= w_gen_nxt;
      r_run <= w_run_nxt;
    end
  end
  assign o_val = r_val;
  assign o_gen = r_gen;
  assign o_run = r_run;
endmodule

// File: rtl/pattern_gen_multi.sv
// pattern_gen_multi: multi-channel LFSR/counter pattern source with pipeIn sequence checker
module pattern_gen_multi import pattern_gen_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(DEFAULT_TAPS),
  parameter int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             okClk,
  input  logic             reset,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic [15:0]      trig,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [15:0]      err_count,
  output logic [7:0]       status
);
  logic [WIDTH-1:0] w_val [CHANNELS];
  gen_e w_gen [CHANNELS];
  run_e w_run [CHANNELS];
  logic w_sel_ok, w_inc, w_unused_trig;
  logic [15:0] r_err;
  assign w_sel_ok = 32'(ch_sel) < CHANNELS;
  assign w_unused_trig = ^trig[15:7];
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic w_hit;
    assign w_hit = w_sel_ok && (ch_sel == SEL_W'(g));
    pattern_chan #(.WIDTH(WIDTH), .TAPS(TAPS)) u_chan (
      .i_clk      (okClk),
      .i_rst      (reset),
      .i_trig     ((trig[TRIG_BCAST] || w_hit) ? trig[4:0] : 5'b0),
      .i_seed_load(w_hit && seed_load),
      .i_seed     (seed),
      .i_step_req (w_hit && (rd_en || wr_en)),
      .o_val      (w_val[g]),
      .o_gen      (w_gen[g]),
      .o_run      (w_run[g])
    );
  end
  // selected-channel readout and mismatch detect against the pre-step word
  always_comb begin
    rd_data = w_sel_ok ? w_val[ch_sel] : '0;
    status = w_sel_ok ? {3'b000, w_run[ch_sel], w_gen[ch_sel]} : 8'h00;
    w_inc = w_sel_ok && wr_en && (wr_data != rd_data);
  end
  // saturating error counter; clear wins over a same-cycle increment
  always_ff @(posedge okClk) begin
    if (reset || trig[TRIG_CLR_ERR]) r_err <= '0;
    else if (w_inc && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
  end
  assign err_count = r_err;
endmodule
